alu_exec_ctrl: RTL and testbench
================================

# alu_exec_ctrl

Execute-stage controller that sits directly upstream of the 8-bit `ALU` and consumes what it produces. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8×8-bit register file. It drives `Rs1`/`Rs2`/`Opcode` into the ALU, captures `Out`/`Carry`, and writes the result back with a sticky-free carry flag and error pulses. It is strictly serial: one instruction in flight, with no hazards.

## Interface
- Parameters: none. Width is fixed at 8-bit data, 8 registers, 4-bit opcode.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  controller can accept
- `in_instr`  in  16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2; LDI: [7:0] imm8
- `alu_rs1`  out  8  to ALU `Rs1`
- `alu_rs2`  out  8  to ALU `Rs2`
- `alu_opcode`  out  4  to ALU `Opcode`
- `alu_out`  in  8  from ALU `Out`
- `alu_carry`  in  1  from ALU `Carry`
- `wb_valid`  out  1  one-cycle pulse: instruction committed
- `wb_rd`  out  3  destination of committed instruction
- `wb_data`  out  8  value written
- `carry_flag`  out  1  carry of last committed ALU op
- `div0_err`  out  1  one-cycle pulse: DIV with rs2 value 0 dropped
- `illegal_err`  out  1  one-cycle pulse: reserved opcode dropped
- `dbg_addr`  in  3  debug read address
- `dbg_data`  out  8  combinational register-file read; r0 reads 0

## Operation
**Opcodes**
- 0000–1001 are ALU ops, passed unchanged to `alu_opcode`.
- 1111 = LDI: rd ← imm8. LDI bypasses the ALU and leaves `carry_flag` unchanged.
- 1010–1110 are reserved (illegal).

**State machine** (state encoding in package): IDLE → READ → EXEC → WB → IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `in_instr` and go to READ. Otherwise stay.
- READ: latch `op1` = R[rs1] and `op2` = R[rs2]; r0 reads as 0. Go to EXEC.
- EXEC: the ALU is driven from `op1`/`op2`/op throughout. Capture `alu_out`/`alu_carry` (or imm8 for LDI) into the result register. Go to WB.
- WB: commit or drop the instruction, raise the appropriate pulse, then go to IDLE.

**Commit rules in WB**
- Illegal op: no write. `illegal_err`=1, `wb_valid`=0.
- DIV (1001) with `op2`==0: no write. `div0_err`=1, `wb_valid`=0, `carry_flag` unchanged.
- Otherwise: `wb_valid`=1, `wb_rd`=rd, `wb_data`=result. Write R[rd] unless rd==0, since r0 writes are ignored but `wb_valid` still pulses.
- `carry_flag` ← captured carry on every committed ALU op. The ALU reports 0 for non-ADD/SUB ops, so those clear it.

**Width rules**: all data is 8-bit, and MUL/DIV/shift truncation is the ALU's responsibility. The controller never modifies `alu_out`.

**Idle outputs**: outside EXEC, `alu_*` hold their last operand-register values, which are don't-care to the ALU.

## Timing
- Reset values:
  - state IDLE; all R[i]=0; `op1`/`op2`/result/instr registers 0.
  - `in_ready`=0 while `rst` is high, 1 in the first cycle after release.
  - `alu_rs1`/`alu_rs2`/`alu_opcode`=0.
  - `wb_valid`/`div0_err`/`illegal_err`/`carry_flag`=0; `wb_rd`/`wb_data`=0.
- Latency: the accept edge at cycle 0 leads to `wb_valid` (or an error pulse) during cycle 3. The register write takes effect at the end of cycle 3.
- `in_ready` is 1 again in cycle 4. Throughput is one instruction per 4 cycles.
- Back-to-back: the next instruction's READ (≥ cycle 5) sees the previous write. No forwarding is needed.
- `in_valid` while `in_ready`=0: ignored. The source must hold the instruction and `in_instr` stable until accepted.
- Reset mid-operation: the in-flight instruction is abandoned, with no write and no pulse. Every register returns to its reset value.
- `dbg_data` is combinational. It reflects a WB write from the next cycle onward.

## Structure
- Package `alu_exec_pkg`:
  - opcode localparams (`OP_ADD`…`OP_DIV`, `OP_LDI`)
  - state enum/localparams (`S_IDLE`, `S_READ`, `S_EXEC`, `S_WB`)
  - instruction field bit positions
- One sub-module `regfile8x8`: two synchronous-registered read paths used in READ, one combinational debug read, one write port, and the r0-zero rule.
- The ALU itself is instantiated at the parent level, not inside this block.

## Test plan
- Reset release → `in_ready`=1 next cycle. LDI r1,0xF0 and LDI r2,0x20, then ADD r3,r1,r2 → `wb_valid` on cycle 3 with `wb_data`=0x10, `wb_rd`=3, `carry_flag`=1. Then `dbg_addr`=3 → `dbg_data`=0x10.
- SUB r4,r2,r1 (0x20−0xF0) → `wb_data`=0x30, `carry_flag`=1. Follow with AND r5,r1,r2 → 0x20, `carry_flag`=0.
- DIV r6,r1,r0 → `div0_err` pulses for exactly one cycle, `wb_valid`=0, R6 unchanged (0), `carry_flag` unchanged.
- Opcode 1100 → `illegal_err` pulse, no write. LDI r0,0x55 → `wb_valid`=1, `wb_rd`=0, `dbg_data`@0 = 0x00.
- Hold `in_valid`=1 continuously with 3 instructions → accepts exactly every 4 cycles, and each result is visible to the next instruction.
- Assert `rst` during EXEC of ADD r7 → no `wb_valid`, R7=0, all outputs at reset values, `in_ready`=1 the cycle after `rst` drops.

Source files
------------

// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_pkg
// Description : Opcodes, FSM encoding and instruction field positions shared
//               by the execute-stage controller and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

    localparam int DATA_W  = 8;
    localparam int NREG    = 8;
    localparam int REG_AW  = 3;
    localparam int OP_W    = 4;
    localparam int INSTR_W = 16;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT = 4'd5;
    localparam logic [OP_W-1:0] OP_SHL = 4'd6;
    localparam logic [OP_W-1:0] OP_SHR = 4'd7;
    localparam logic [OP_W-1:0] OP_MUL = 4'd8;
    localparam logic [OP_W-1:0] OP_DIV = 4'd9;
    localparam logic [OP_W-1:0] OP_LDI = 4'd15;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes above DIV other than LDI have no meaning and are dropped.
    function automatic logic is_reserved_op(input logic [OP_W-1:0] op);
        return (op > OP_DIV) && (op != OP_LDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile8x8.sv
`default_nettype none
// ============================================================================
// Module      : regfile8x8
// Description : 8x8 register file, two registered operand reads, one write,
//               one combinational debug read; r0 is hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile8x8
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              we,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] r_mem_q [NREG];
    logic [DATA_W-1:0] w_mem_d [NREG];
    logic [DATA_W-1:0] r_rd1_q, w_rd1_d;
    logic [DATA_W-1:0] r_rd2_q, w_rd2_d;

    always_comb begin
        w_mem_d = r_mem_q;
        w_rd1_d = r_rd1_q;
        w_rd2_d = r_rd2_q;
        if (we && (wr_addr != '0)) begin
            w_mem_d[wr_addr] = wr_data;
        end
        if (rd_en) begin
            w_rd1_d = (rd_addr1 == '0) ? '0 : r_mem_q[rd_addr1];
            w_rd2_d = (rd_addr2 == '0) ? '0 : r_mem_q[rd_addr2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem_q[i] <= '0;
            end
            r_rd1_q <= '0;
            r_rd2_q <= '0;
        end else begin
            r_mem_q <= w_mem_d;
            r_rd1_q <= w_rd1_d;
            r_rd2_q <= w_rd2_d;
        end
    end

    assign rd_data1 = r_rd1_q;
    assign rd_data2 = r_rd2_q;
    assign dbg_data = (dbg_addr == '0) ? '0 : r_mem_q[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_ctrl
// Description : Serial execute-stage controller: IDLE->READ->EXEC->WB around
//               an external 8-bit ALU, with writeback and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl
    import alu_exec_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic [DATA_W-1:0]  alu_rs1,
    output logic [DATA_W-1:0]  alu_rs2,
    output logic [OP_W-1:0]    alu_opcode,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_carry,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic               carry_flag,
    output logic               div0_err,
    output logic               illegal_err,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    logic [1:0]         r_state_q, w_state_d;
    logic [INSTR_W-1:0] r_instr_q, w_instr_d;
    logic [DATA_W-1:0]  r_result_q, w_result_d;
    logic               r_carry_cap_q, w_carry_cap_d;
    logic               r_carry_flag_q, w_carry_flag_d;

    logic [OP_W-1:0]    w_op;
    logic [REG_AW-1:0]  w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0]  w_imm, w_op1, w_op2;
    logic               w_accept, w_read_en, w_is_ldi, w_reserved, w_div0, w_commit;

    assign w_op       = r_instr_q[OP_MSB:OP_LSB];
    assign w_rd       = r_instr_q[RD_MSB:RD_LSB];
    assign w_rs1      = r_instr_q[RS1_MSB:RS1_LSB];
    assign w_rs2      = r_instr_q[RS2_MSB:RS2_LSB];
    assign w_imm      = r_instr_q[IMM_MSB:IMM_LSB];
    assign w_accept   = in_valid && in_ready;
    assign w_read_en  = (r_state_q == S_READ);
    assign w_is_ldi   = (w_op == OP_LDI);
    assign w_reserved = is_reserved_op(w_op);
    assign w_div0     = (w_op == OP_DIV) && (w_op2 == '0);
    assign w_commit   = !w_reserved && !w_div0;

    regfile8x8 u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (w_read_en),
        .rd_addr1 (w_rs1),
        .rd_addr2 (w_rs2),
        .rd_data1 (w_op1),
        .rd_data2 (w_op2),
        .we       (wb_valid),
        .wr_addr  (w_rd),
        .wr_data  (r_result_q),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:  if (w_accept) w_state_d = S_READ;
            S_READ:  w_state_d = S_EXEC;
            S_EXEC:  w_state_d = S_WB;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_instr_d      = r_instr_q;
        w_result_d     = r_result_q;
        w_carry_cap_d  = r_carry_cap_q;
        w_carry_flag_d = r_carry_flag_q;
        if ((r_state_q == S_IDLE) && w_accept) begin
            w_instr_d = in_instr;
        end
        if (r_state_q == S_EXEC) begin
            w_result_d    = w_is_ldi ? w_imm : alu_out;
            w_carry_cap_d = w_is_ldi ? 1'b0 : alu_carry;
        end
        // LDI never touched the ALU, so its captured carry is meaningless.
        if ((r_state_q == S_WB) && w_commit && !w_is_ldi) begin
            w_carry_flag_d = r_carry_cap_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_q      <= '0;
            r_result_q     <= '0;
            r_carry_cap_q  <= 1'b0;
            r_carry_flag_q <= 1'b0;
        end else begin
            r_instr_q      <= w_instr_d;
            r_result_q     <= w_result_d;
            r_carry_cap_q  <= w_carry_cap_d;
            r_carry_flag_q <= w_carry_flag_d;
        end
    end

    always_comb begin
        in_ready    = (r_state_q == S_IDLE) && !rst;
        alu_rs1     = w_op1;
        alu_rs2     = w_op2;
        alu_opcode  = w_op;
        wb_valid    = (r_state_q == S_WB) && w_commit;
        div0_err    = (r_state_q == S_WB) && w_div0;
        illegal_err = (r_state_q == S_WB) && w_reserved;
        wb_rd       = w_rd;
        wb_data     = r_result_q;
        carry_flag  = r_carry_flag_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_ctrl
// Description : Directed bench with an instruction-level reference model and
//               an ALU model standing in for the downstream 8-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_ctrl;
    import alu_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [15:0] in_instr;
    logic [7:0]  alu_rs1, alu_rs2, alu_out, wb_data, dbg_data;
    logic [3:0]  alu_opcode;
    logic        alu_carry, wb_valid, carry_flag, div0_err, illegal_err;
    logic [2:0]  wb_rd, dbg_addr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_carry(alu_carry),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .carry_flag(carry_flag), .div0_err(div0_err), .illegal_err(illegal_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // {carry, out} of the downstream ALU; carry is the borrow for SUB.
    function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {a < b, a - b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOT:  return {1'b0, ~a};
            OP_SHL:  return {1'b0, a << b[2:0]};
            OP_SHR:  return {1'b0, a >> b[2:0]};
            OP_MUL:  return {1'b0, p[7:0]};
            OP_DIV:  return (b == 8'd0) ? 9'h0FF : {1'b0, a / b};
            default: return 9'h000;
        endcase
    endfunction

    always_comb {alu_carry, alu_out} = alu_ref(alu_opcode, alu_rs1, alu_rs2);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    typedef struct packed {
        logic       commit;
        logic       div0;
        logic       ill;
        logic       upd;
        logic [2:0] rd;
        logic [7:0] data;
        logic       carry;
    } outc_t;

    logic [7:0] m_regs [8];
    logic       m_carry = 1'b0;
    int         m_cnt = 0;
    outc_t      m_pend = '0;
    logic       m_rst_seen = 1'b0;

    function automatic outc_t predict(input logic [15:0] ins);
        outc_t      o;
        logic [7:0] a, b;
        logic [8:0] r;
        logic [3:0] op;
        o    = '0;
        op   = ins[15:12];
        a    = (ins[8:6] == 3'd0) ? 8'd0 : m_regs[ins[8:6]];
        b    = (ins[5:3] == 3'd0) ? 8'd0 : m_regs[ins[5:3]];
        o.rd = ins[11:9];
        if (op == OP_LDI) begin
            o.commit = 1'b1;
            o.data   = ins[7:0];
        end else if (op > OP_DIV) begin
            o.ill = 1'b1;
        end else if (op == OP_DIV && b == 8'd0) begin
            o.div0 = 1'b1;
        end else begin
            r        = alu_ref(op, a, b);
            o.commit = 1'b1;
            o.upd    = 1'b1;
            o.data   = r[7:0];
            o.carry  = r[8];
        end
        return o;
    endfunction

    initial for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;

    // m_cnt counts the busy cycles left; the writeback cycle is m_cnt==1.
    always @(posedge clk) begin
        m_rst_seen <= rst;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= 8'd0;
            m_carry <= 1'b0;
            m_cnt   <= 0;
            m_pend  <= '0;
        end else if (m_cnt > 0) begin
            if (m_cnt == 1 && m_pend.commit) begin
                if (m_pend.rd != 3'd0) m_regs[m_pend.rd] <= m_pend.data;
                if (m_pend.upd) m_carry <= m_pend.carry;
            end
            m_cnt <= m_cnt - 1;
        end else if (in_valid) begin
            m_pend <= predict(in_instr);
            m_cnt  <= 3;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, !rst && m_cnt == 0);
            chk("wb_valid", wb_valid, !m_rst_seen && m_cnt == 1 && m_pend.commit);
            chk("div0_err", div0_err, !m_rst_seen && m_cnt == 1 && m_pend.div0);
            chk("illegal_err", illegal_err, !m_rst_seen && m_cnt == 1 && m_pend.ill);
            chk("carry_flag", carry_flag, m_carry);
            chk("dbg_data", dbg_data, (dbg_addr == 3'd0) ? 8'd0 : m_regs[dbg_addr]);
            if (!m_rst_seen && m_cnt == 1 && m_pend.commit) begin
                chk("wb_rd", wb_rd, m_pend.rd);
                chk("wb_data", wb_data, m_pend.data);
            end
            if (m_rst_seen) begin
                chk("rst_wb_rd", wb_rd, 0);
                chk("rst_wb_data", wb_data, 0);
                chk("rst_alu_rs1", alu_rs1, 0);
                chk("rst_alu_rs2", alu_rs2, 0);
                chk("rst_alu_opcode", alu_opcode, 0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    time acc_t[$];

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {OP_LDI, rd, 1'b0, imm};
    endfunction

    // Leaves in_valid high so callers can stream instructions back to back.
    task automatic issue(input logic [15:0] ins);
        logic acc;
        bit   done;
        done     = 1'b0;
        in_instr = ins;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) acc_t.push_back($time);
            @(posedge clk);
            if (acc) done = 1'b1;
        end
        #2;
        if (!done) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end
    endtask

    // kind: 1 writeback, 2 div0, 3 illegal, 0 nothing within the bound
    task automatic wait_res(output int kind, output logic [7:0] d, output logic [2:0] rd);
        kind = 0;
        d    = 8'd0;
        rd   = 3'd0;
        for (int k = 0; k < 8 && kind == 0; k++) begin
            @(negedge clk);
            if (wb_valid)         begin kind = 1; d = wb_data; rd = wb_rd; end
            else if (div0_err)    kind = 2;
            else if (illegal_err) kind = 3;
        end
        #1;
    endtask

    task automatic run(input string name, input logic [15:0] ins, input int ekind,
                       input logic [7:0] edata, input logic [2:0] erd, input logic ecarry);
        int         kind;
        logic [7:0] d;
        logic [2:0] rd;
        issue(ins);
        in_valid = 1'b0;
        wait_res(kind, d, rd);
        chk({name, "_kind"}, kind, ekind);
        if (ekind == 1) begin
            chk({name, "_data"}, d, edata);
            chk({name, "_rd"}, rd, erd);
        end
        @(posedge clk);
        #1;
        chk({name, "_carry"}, carry_flag, ecarry);
        chk({name, "_pulses_off"}, {wb_valid, div0_err, illegal_err}, 0);
    endtask

    task automatic peek(input logic [2:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), dbg_data, exp);
    endtask

    initial begin
        int         kind;
        logic [7:0] d;
        logic [2:0] rd;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        dbg_addr = 3'd0;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_reset", in_ready, 1);
        for (int i = 0; i < 8; i++) peek(3'(i), 8'h00);

        run("ldi_r1", ldi(3'd1, 8'hF0), 1, 8'hF0, 3'd1, 1'b0);
        run("ldi_r2", ldi(3'd2, 8'h20), 1, 8'h20, 3'd2, 1'b0);
        run("add_r3", enc(OP_ADD, 3'd3, 3'd1, 3'd2), 1, 8'h10, 3'd3, 1'b1);
        peek(3'd3, 8'h10);
        run("sub_r4", enc(OP_SUB, 3'd4, 3'd2, 3'd1), 1, 8'h30, 3'd4, 1'b1);
        run("div0_r6", enc(OP_DIV, 3'd6, 3'd1, 3'd0), 2, 8'h00, 3'd0, 1'b1);
        peek(3'd6, 8'h00);
        run("and_r5", enc(OP_AND, 3'd5, 3'd1, 3'd2), 1, 8'h20, 3'd5, 1'b0);
        run("illegal", enc(4'b1100, 3'd5, 3'd1, 3'd2), 3, 8'h00, 3'd0, 1'b0);
        peek(3'd5, 8'h20);
        run("ldi_r0", ldi(3'd0, 8'h55), 1, 8'h55, 3'd0, 1'b0);
        peek(3'd0, 8'h00);

        acc_t.delete();
        issue(enc(OP_ADD, 3'd2, 3'd1, 3'd1));
        issue(enc(OP_ADD, 3'd3, 3'd2, 3'd2));
        issue(enc(OP_XOR, 3'd4, 3'd3, 3'd1));
        in_valid = 1'b0;
        wait_res(kind, d, rd);
        chk("stream_kind", kind, 1);
        chk("stream_data", d, 8'h30);
        chk("stream_rd", rd, 3'd4);
        chk("stream_accepts", acc_t.size(), 3);
        if (acc_t.size() == 3) begin
            chk("stream_gap1", 32'(acc_t[1] - acc_t[0]), 40);
            chk("stream_gap2", 32'(acc_t[2] - acc_t[1]), 40);
        end
        @(posedge clk);
        #1;
        peek(3'd2, 8'hE0);
        peek(3'd3, 8'hC0);
        peek(3'd4, 8'h30);

        issue(enc(OP_ADD, 3'd7, 3'd1, 3'd2));
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_carry", carry_flag, 0);
        chk("mid_rst_alu_rs1", alu_rs1, 0);
        peek(3'd7, 8'h00);
        peek(3'd1, 8'h00);
        repeat (6) @(posedge clk);
        #1;
        peek(3'd7, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
